// File: rtl/pio_in_debounce_edge.sv
// Avalon-MM parallel input port: per-bit synchroniser, debounce filter,
// rise/fall edge capture (W1C) and edge- or level-based interrupt.
module pio_in_debounce_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DB_W        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_THRESH  = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;
  localparam logic [2:0] ADDR_RAW     = 3'd7;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  raw;
  logic [WIDTH-1:0]                  db_q, db_d, db_dly_q;
  logic [WIDTH-1:0][DB_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  rise_en_q, fall_en_q, mask_q;
  logic [WIDTH-1:0]                  ecap_q, ecap_d;
  logic [DB_W-1:0]                   thresh_q;
  logic                              ctrl_q;
  logic [31:0]                       rd_d;
  logic                              wr_en;
  logic [WIDTH-1:0]                  rise, fall, clr;

  assign raw   = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect & ~write_n;

  // A zero threshold bypasses the filter; otherwise db takes raw once the
  // counter has reached the threshold while raw still disagrees.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (thresh_q == '0) begin
        db_d[i] = raw[i];
      end else if (raw[i] != db_q[i]) begin
        if (cnt_q[i] == thresh_q) begin
          db_d[i] = raw[i];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  assign rise   = db_q & ~db_dly_q & rise_en_q;
  assign fall   = ~db_q & db_dly_q & fall_en_q;
  assign clr    = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  // New edges are OR-ed in after the clear so a simultaneous set wins.
  assign ecap_d = (ecap_q & ~clr) | rise | fall;

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:    rd_d[WIDTH-1:0] = db_q;
      ADDR_RISE_EN: rd_d[WIDTH-1:0] = rise_en_q;
      ADDR_MASK:    rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_d[WIDTH-1:0] = ecap_q;
      ADDR_FALL_EN: rd_d[WIDTH-1:0] = fall_en_q;
      ADDR_THRESH:  rd_d[DB_W-1:0]  = thresh_q;
      ADDR_CTRL:    rd_d[0]         = ctrl_q;
      ADDR_RAW:     rd_d[WIDTH-1:0] = raw;
      default:      rd_d            = '0;
    endcase
  end

  assign irq = ctrl_q ? |(db_q & mask_q) : |(ecap_q & mask_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      cnt_q     <= '0;
      ecap_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
      thresh_q  <= '0;
      ctrl_q    <= 1'b0;
      readdata  <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
      ecap_q   <= ecap_d;
      readdata <= rd_d;
      if (wr_en) begin
        case (address)
          ADDR_RISE_EN: rise_en_q <= writedata[WIDTH-1:0];
          ADDR_MASK:    mask_q    <= writedata[WIDTH-1:0];
          ADDR_FALL_EN: fall_en_q <= writedata[WIDTH-1:0];
          ADDR_THRESH:  thresh_q  <= writedata[DB_W-1:0];
          ADDR_CTRL:    ctrl_q    <= writedata[0];
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_in_debounce_edge.sv
// Directed scenarios plus randomized input traffic for pio_in_debounce_edge,
// checked against a streak-based reference model of the debounced port.
module tb_pio_in_debounce_edge;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DB_W  = 16;
  localparam int unsigned SS    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  pio_in_debounce_edge #(.WIDTH(WIDTH), .DB_W(DB_W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw is the input as sampled SS edges ago; db adopts raw
  // once raw has disagreed with it for thresh+1 consecutive samples.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_db, m_dbd, m_ecap, m_rise_en, m_fall_en, m_mask;
  logic [DB_W-1:0]  m_thresh;
  logic             m_ctrl;
  logic [31:0]      m_rd;
  logic             m_irq;
  int unsigned      streak[WIDTH];

  function automatic logic [WIDTH-1:0] m_raw();
    return (hist.size() >= SS) ? hist[SS-1] : '0;
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] raw, db_n, rise, fall, clr;
    if (reset) begin
      hist.delete();
      m_db = '0; m_dbd = '0; m_ecap = '0; m_rise_en = '0; m_fall_en = '0;
      m_mask = '0; m_thresh = '0; m_ctrl = 1'b0; m_rd = '0;
      for (int i = 0; i < WIDTH; i++) streak[i] = 0;
    end else begin
      raw = m_raw();
      case (address)
        3'd0: m_rd = 32'(m_db);
        3'd1: m_rd = 32'(m_rise_en);
        3'd2: m_rd = 32'(m_mask);
        3'd3: m_rd = 32'(m_ecap);
        3'd4: m_rd = 32'(m_fall_en);
        3'd5: m_rd = 32'(m_thresh);
        3'd6: m_rd = 32'(m_ctrl);
        default: m_rd = 32'(raw);
      endcase
      rise = m_db & ~m_dbd & m_rise_en;
      fall = ~m_db & m_dbd & m_fall_en;
      clr  = (chipselect && !write_n && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
      db_n = m_db;
      for (int i = 0; i < WIDTH; i++) begin
        if (raw[i] != m_db[i]) begin
          streak[i]++;
          if (streak[i] > m_thresh) begin
            db_n[i] = raw[i];
            streak[i] = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
      m_dbd  = m_db;
      m_db   = db_n;
      m_ecap = (m_ecap & ~clr) | rise | fall;
      if (chipselect && !write_n) begin
        case (address)
          3'd1: m_rise_en = writedata[WIDTH-1:0];
          3'd2: m_mask    = writedata[WIDTH-1:0];
          3'd4: m_fall_en = writedata[WIDTH-1:0];
          3'd5: m_thresh  = writedata[DB_W-1:0];
          3'd6: m_ctrl    = writedata[0];
          default: ;
        endcase
      end
      hist.push_front(in_port);
      if (hist.size() > SS) void'(hist.pop_back());
    end
    m_irq = m_ctrl ? |(m_db & m_mask) : |(m_ecap & m_mask);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_readdata", readdata, m_rd);
    check("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] flip;
    logic [2:0]       ra;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    tick(); tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;

    // Bypass filter: rise captured SS+2 edges after the input changes
    wr(3'd1, 32'hFF); wr(3'd2, 32'h01);
    in_port = 8'h01; address = 3'd3;
    repeat (SS + 1) tick();
    check("bypass_irq_early", 32'(irq), 32'h0);
    tick();
    check("bypass_irq", 32'(irq), 32'h1);
    tick();
    check("bypass_edgecap", readdata, 32'h1);
    wr(3'd3, 32'h1);
    check("w1c_irq", 32'(irq), 32'h0);
    tick();
    check("w1c_edgecap", readdata, 32'h0);

    // Threshold 4: latency, glitch rejection, single fall capture
    reset_dut();
    wr(3'd5, 32'h4); wr(3'd4, 32'h2);
    in_port = 8'h02; address = 3'd0;
    repeat (SS + 5) tick();
    check("db_latency_early", readdata, 32'h0);
    tick();
    check("db_latency", readdata, 32'h2);
    repeat (4) tick();
    in_port = 8'h00;
    repeat (3) tick();
    in_port = 8'h02;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_data", readdata, 32'h2);
    end
    address = 3'd3;
    tick();
    check("glitch_edgecap", readdata, 32'h0);
    in_port = 8'h00;
    repeat (10) tick();
    check("fall_edgecap", readdata, 32'h2);
    wr(3'd3, 32'h2);
    repeat (5) tick();
    check("fall_once", readdata, 32'h0);

    // W1C in the same cycle as a new rise: set wins
    reset_dut();
    wr(3'd1, 32'h01);
    in_port = 8'h01;
    repeat (SS + 1) tick();
    wr(3'd3, 32'h1);
    address = 3'd3;
    tick();
    check("set_wins", readdata, 32'h1);

    // Level interrupt follows debounced bit 7
    reset_dut();
    wr(3'd6, 32'h1); wr(3'd2, 32'h80);
    in_port = 8'h80;
    repeat (SS) tick();
    check("level_irq_pre", 32'(irq), 32'h0);
    tick();
    check("level_irq_hi", 32'(irq), 32'h1);
    in_port = 8'h00;
    repeat (SS) tick();
    check("level_irq_hold", 32'(irq), 32'h1);
    tick();
    check("level_irq_lo", 32'(irq), 32'h0);

    // Threshold register width, ignored upper bits, raw readback, RO writes
    wr(3'd5, 32'h1234ABCD);
    address = 3'd5;
    tick();
    check("thresh_read", readdata, 32'h0000ABCD);
    in_port = 8'h5A;
    repeat (SS + 1) tick();
    wr(3'd7, 32'hFFFFFFFF);
    wr(3'd0, 32'hFFFFFFFF);
    address = 3'd7;
    tick();
    check("raw_read", readdata, 32'h0000005A);

    // Reset in the middle of a debounce count
    reset_dut();
    wr(3'd1, 32'hFF); wr(3'd2, 32'hFF); wr(3'd4, 32'hFF); wr(3'd6, 32'h1); wr(3'd5, 32'h4);
    in_port = 8'h01;
    repeat (SS + 2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: address = 3'd1;
        1: address = 3'd2;
        2: address = 3'd4;
        3: address = 3'd5;
        default: address = 3'd6;
      endcase
      tick();
      check("midreset_reg", readdata, 32'h0);
    end

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      reset_dut();
      wr(3'd5, 32'($urandom_range(0, 5)));
      wr(3'd1, $urandom); wr(3'd4, $urandom); wr(3'd2, $urandom);
      wr(3'd6, 32'($urandom_range(0, 1)));
      for (int c = 0; c < 150; c++) begin
        for (int b = 0; b < WIDTH; b++) flip[b] = ($urandom_range(0, 7) == 0);
        in_port = in_port ^ flip;
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 2))
            0: ra = 3'd0;
            1: ra = 3'd3;
            default: ra = 3'd7;
          endcase
          wr(ra, $urandom);
        end else begin
          address = 3'($urandom_range(0, 7));
          tick();
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
